// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter in front of one shared memory
// Purpose: grants the single memory to the instruction-fetch port (read-only)
//   or the data port (load/store), alternating when both request, and runs
//   each transfer as a req/ack handshake with alignment and write-timeout checks.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   if_req/if_addr              fetch request, address held until if_ack
//   if_ack/if_rdata/if_err      fetch completion pulse, word, misalignment flag
//   d_req/d_addr/d_size/d_wdata data request (size 00 rd word, 01/10/11 wr b/h/w)
//   d_ack/d_rdata/d_err         data completion pulse, load word, error flag
//   mem_address/mem_write/mem_wdata/mem_rdata/mem_done  memory side
//   busy                        high whenever a transfer is in progress
module mem_port_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int READ_LAT   = 2,
  parameter int WR_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_ack,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 d_req,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [1:0]           d_size,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_err,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [1:0]           mem_write,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_done,
  output logic                 busy
);

  localparam int CNT_MAX = (READ_LAT > WR_TIMEOUT) ? READ_LAT : WR_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, ERR} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           gnt_d, gnt_d_nxt;    // 1: current transfer belongs to the data port
  logic           last_d, last_d_nxt;  // 1: most recent grant went to the data port

  logic [WORD_SIZE-1:0] mem_address_nxt, mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;
  logic [1:0]           mem_write_nxt;
  logic                 if_ack_nxt, if_err_nxt, d_ack_nxt, d_err_nxt, busy_nxt;

  logic any_req, pick_d, if_mis, d_mis, win_mis, win_wr, cnt_is_one;

  // Data wins when it is the only requester, or when both request and the
  // previous grant was a fetch. last_d resets to 1 so fetch goes first.
  assign any_req    = if_req | d_req;
  assign pick_d     = d_req & (~if_req | ~last_d);
  assign win_mis    = pick_d ? d_mis : if_mis;
  assign win_wr     = pick_d & (d_size != 2'b00);
  assign cnt_is_one = (cnt == CW'(1));

  always_comb begin
    if_mis = (if_addr[1:0] != 2'b00);
    case (d_size)
      2'b01:   d_mis = 1'b0;
      2'b10:   d_mis = d_addr[0];
      default: d_mis = (d_addr[1:0] != 2'b00);
    endcase
  end

  // State register plus the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt_d       <= 1'b0;
      last_d      <= 1'b1;
      mem_address <= '0;
      mem_write   <= 2'b00;
      mem_wdata   <= '0;
      if_ack      <= 1'b0;
      if_err      <= 1'b0;
      if_rdata    <= '0;
      d_ack       <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      gnt_d       <= gnt_d_nxt;
      last_d      <= last_d_nxt;
      mem_address <= mem_address_nxt;
      mem_write   <= mem_write_nxt;
      mem_wdata   <= mem_wdata_nxt;
      if_ack      <= if_ack_nxt;
      if_err      <= if_err_nxt;
      if_rdata    <= if_rdata_nxt;
      d_ack       <= d_ack_nxt;
      d_err       <= d_err_nxt;
      d_rdata     <= d_rdata_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (win_mis)     state_nxt = ERR;
          else if (win_wr) state_nxt = WRITE;
          else             state_nxt = READ;
        end
      end
      READ:    if (cnt_is_one) state_nxt = IDLE;
      WRITE:   if (mem_done || cnt_is_one) state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for every registered output.
  always_comb begin
    cnt_nxt         = cnt;
    gnt_d_nxt       = gnt_d;
    last_d_nxt      = last_d;
    mem_address_nxt = mem_address;
    mem_write_nxt   = mem_write;
    mem_wdata_nxt   = mem_wdata;
    if_ack_nxt      = 1'b0;
    if_err_nxt      = 1'b0;
    if_rdata_nxt    = if_rdata;
    d_ack_nxt       = 1'b0;
    d_err_nxt       = 1'b0;
    d_rdata_nxt     = d_rdata;
    busy_nxt        = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_d_nxt  = pick_d;
          last_d_nxt = pick_d;
          // A misaligned request never touches the memory interface.
          if (!win_mis) begin
            mem_address_nxt = pick_d ? d_addr : if_addr;
            if (win_wr) begin
              mem_write_nxt = d_size;
              mem_wdata_nxt = d_wdata;
              cnt_nxt       = CW'(WR_TIMEOUT);
            end else begin
              mem_write_nxt = 2'b00;
              cnt_nxt       = CW'(READ_LAT);
            end
          end
        end
      end
      READ: begin
        if (cnt_is_one) begin
          if (gnt_d) begin
            d_ack_nxt   = 1'b1;
            d_rdata_nxt = mem_rdata;
          end else begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = mem_rdata;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      WRITE: begin
        // mem_done takes priority over a timeout landing in the same cycle.
        if (mem_done || cnt_is_one) begin
          d_ack_nxt     = 1'b1;
          d_err_nxt     = ~mem_done;
          mem_write_nxt = 2'b00;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ERR: begin
        if (gnt_d) begin
          d_ack_nxt   = 1'b1;
          d_err_nxt   = 1'b1;
          d_rdata_nxt = '0;
        end else begin
          if_ack_nxt   = 1'b1;
          if_err_nxt   = 1'b1;
          if_rdata_nxt = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed-vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size, mem_write;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_done, busy;

  int nvec = 0;
  int nmis = 0;
  int nz_cycles = 0;
  int lat;

  mem_port_arbiter #(.WORD_SIZE(32), .READ_LAT(2), .WR_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mem_write != 2'b00) nz_cycles++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Counts negedges from the request cycle until the chosen ack is seen; -1 on timeout.
  task automatic wait_ack(input bit dport, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (dport ? d_ack : if_ack) return;
    end
    cycles = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_addr = 0; d_size = 0;
    d_wdata = 0; mem_rdata = 0; mem_done = 0;
    repeat (2) @(negedge clk);
    chk("rst_if_ack", {31'd0, if_ack}, 0);
    chk("rst_d_ack", {31'd0, d_ack}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_mem_write", {30'd0, mem_write}, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_if_rdata", if_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: lone fetch, latency READ_LAT+1
    mem_rdata = 32'hDEADBEEF; if_addr = 32'h10; if_req = 1;
    wait_ack(0, 10, lat);
    if_req = 0;
    chk("t1_latency", lat, 3);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_if_err", {31'd0, if_err}, 0);
    chk("t1_mem_address", mem_address, 32'h10);
    chk("t1_busy_ack", {31'd0, busy}, 0);
    @(negedge clk);

    // 2: simultaneous requests from reset: fetch first, then data, then fetch
    do_reset();
    mem_rdata = 32'hA5A50001; if_addr = 32'h30; d_addr = 32'h20; d_size = 2'b00;
    if_req = 1; d_req = 1;
    wait_ack(0, 10, lat);
    chk("t2_fetch_first", lat, 3);
    chk("t2_no_d_ack", {31'd0, d_ack}, 0);
    chk("t2_if_rdata", if_rdata, 32'hA5A50001);
    if_addr = 32'h34; mem_rdata = 32'h00002222;
    wait_ack(1, 10, lat);
    chk("t2_data_next", lat, 3);
    chk("t2_d_rdata", d_rdata, 32'h00002222);
    chk("t2_d_err", {31'd0, d_err}, 0);
    chk("t2_if_rdata_held", if_rdata, 32'hA5A50001);
    d_req = 0; mem_rdata = 32'h00003333;
    wait_ack(0, 10, lat);
    if_req = 0;
    chk("t2_fetch_again", lat, 3);
    chk("t2_if_rdata2", if_rdata, 32'h00003333);
    chk("t2_mem_address", mem_address, 32'h34);
    @(negedge clk);

    // 3: word write, mem_done raised in the fourth write cycle
    nz_cycles = 0;
    d_addr = 32'h40; d_size = 2'b11; d_wdata = 32'h12345678; d_req = 1;
    @(negedge clk);
    chk("t3_mem_write", {30'd0, mem_write}, 32'd3);
    chk("t3_mem_address", mem_address, 32'h40);
    chk("t3_mem_wdata", mem_wdata, 32'h12345678);
    chk("t3_busy", {31'd0, busy}, 1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    mem_done = 1;
    @(negedge clk);
    mem_done = 0;
    chk("t3_d_ack", {31'd0, d_ack}, 1);
    chk("t3_d_err", {31'd0, d_err}, 0);
    chk("t3_mem_write_ack", {30'd0, mem_write}, 0);
    chk("t3_write_cycles", nz_cycles, 4);
    d_req = 0;
    @(negedge clk);

    // 4a: byte write at an odd address is legal
    d_addr = 32'h43; d_size = 2'b01; d_wdata = 32'h000000AB; d_req = 1;
    @(negedge clk);
    chk("t4_byte_mem_write", {30'd0, mem_write}, 32'd1);
    chk("t4_byte_addr", mem_address, 32'h43);
    mem_done = 1;
    @(negedge clk);
    mem_done = 0;
    chk("t4_byte_ack", {31'd0, d_ack}, 1);
    chk("t4_byte_err", {31'd0, d_err}, 0);
    d_req = 0;
    @(negedge clk);

    // 4b: misaligned half write, then misaligned fetch
    nz_cycles = 0;
    d_addr = 32'h43; d_size = 2'b10; d_req = 1;
    wait_ack(1, 10, lat);
    d_req = 0;
    chk("t4_half_latency", lat, 2);
    chk("t4_half_err", {31'd0, d_err}, 1);
    chk("t4_half_rdata", d_rdata, 0);
    chk("t4_half_no_write", nz_cycles, 0);
    chk("t4_addr_kept", mem_address, 32'h43);
    @(negedge clk);
    d_addr = 32'h42; d_size = 2'b11; d_req = 1;
    wait_ack(1, 10, lat);
    d_req = 0;
    chk("t4_word_err", {31'd0, d_err}, 1);
    chk("t4_word_no_write", nz_cycles, 0);
    @(negedge clk);
    if_addr = 32'h6; if_req = 1;
    wait_ack(0, 10, lat);
    if_req = 0;
    chk("t4_if_latency", lat, 2);
    chk("t4_if_err", {31'd0, if_err}, 1);
    chk("t4_if_rdata", if_rdata, 0);
    @(negedge clk);

    // 5: write timeout then a normal fetch
    nz_cycles = 0;
    d_addr = 32'h80; d_size = 2'b11; d_wdata = 32'h55; d_req = 1;
    wait_ack(1, 40, lat);
    d_req = 0;
    chk("t5_timeout_latency", lat, 17);
    chk("t5_timeout_err", {31'd0, d_err}, 1);
    chk("t5_write_cycles", nz_cycles, 16);
    chk("t5_mem_write_ack", {30'd0, mem_write}, 0);
    @(negedge clk);
    mem_rdata = 32'h0BADF00D; if_addr = 32'h100; if_req = 1;
    wait_ack(0, 10, lat);
    if_req = 0;
    chk("t5_fetch_latency", lat, 3);
    chk("t5_fetch_err", {31'd0, if_err}, 0);
    chk("t5_fetch_rdata", if_rdata, 32'h0BADF00D);
    @(negedge clk);

    // 6: reset in the middle of a write
    d_addr = 32'h90; d_size = 2'b11; d_wdata = 32'h77; d_req = 1;
    repeat (3) @(negedge clk);
    chk("t6_pre_write", {30'd0, mem_write}, 32'd3);
    rst = 1; d_req = 0;
    #1;
    chk("t6_async_mem_write", {30'd0, mem_write}, 0);
    chk("t6_async_busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("t6_no_ack_rst", {31'd0, d_ack}, 0);
    rst = 0;
    @(negedge clk);
    chk("t6_no_ack_after", {31'd0, d_ack}, 0);
    chk("t6_idle", {31'd0, busy}, 0);
    mem_rdata = 32'h0000600D; if_addr = 32'h200; if_req = 1;
    wait_ack(0, 10, lat);
    if_req = 0;
    chk("t6_fetch_latency", lat, 3);
    chk("t6_fetch_rdata", if_rdata, 32'h0000600D);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
